// File: rtl/ifetch.sv
// Instruction fetch front end. Drives the instruction memory address, pairs
// each returned word with its PC and hands (pc, instr) to decode over a
// valid/ready handshake. A single skid entry holds the word in flight when
// decode stalls. A redirect flushes everything in flight and restarts fetch.
`timescale 1ns / 1ps

module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [31:0] req_pc_q, req_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic stall;
  logic issue;

  // Low address bits of a redirect target are ignored.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_addr = req_pc_q;

  // Output mux: the skid entry is always older than the live response.
  always_comb begin
    if (skid_valid_q) begin
      out_pc    = skid_pc_q;
      out_instr = skid_instr_q;
    end else begin
      out_pc    = resp_pc_q;
      out_instr = imem_rdata;
    end
    out_valid = (skid_valid_q | resp_valid_q) & ~redirect_valid;
    stall     = out_valid & ~out_ready;
    issue     = ~stall & ~redirect_valid;
  end

  // Next-state: redirect beats stall beats issue.
  always_comb begin
    req_pc_d     = req_pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (redirect_valid) begin
      req_pc_d     = {redirect_pc[31:2], 2'b00};
      resp_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (issue) begin
        resp_pc_d    = req_pc_q;
        resp_valid_d = 1'b1;
        req_pc_d     = req_pc_q + 32'd4;
      end else begin
        // The word arriving next cycle is dropped; req_pc re-fetches it.
        resp_valid_d = 1'b0;
      end
      if (stall && !skid_valid_q && resp_valid_q) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = resp_pc_q;
        skid_instr_d = imem_rdata;
      end else if (skid_valid_q && out_ready) begin
        skid_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q     <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
    end else begin
      req_pc_q     <= req_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios followed by random back-pressure and
// redirects, checked against an in-order program-counter scoreboard.
`timescale 1ns / 1ps

module tb_ifetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Key     = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int errors = 0;
  int checks = 0;

  // Scoreboard state: next PC decode must receive, plus hold tracking.
  logic [31:0] exp_pc;
  int          n_acc;
  int          idle;
  logic        prev_stall;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic        obs_valid;
  logic [31:0] obs_pc;

  ifetch #(.RESET_PC(ResetPc)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model: registered read, 1-cycle latency, no enable.
  initial imem_rdata = 32'h0;
  always @(posedge clk) imem_rdata <= imem_addr ^ Key;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  // resp and skid must never both be occupied.
  always @(negedge clk) begin
    check("resp_skid_excl", {31'b0, dut.resp_valid_q & dut.skid_valid_q}, 32'h0);
  end

  task automatic sb_reset();
    exp_pc     = ResetPc;
    idle       = 0;
    prev_stall = 1'b0;
  endtask

  // One cycle: drive inputs after negedge, sample outputs 1ns later.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    obs_valid = out_valid;
    obs_pc    = out_pc;
    if (rv) begin
      check("redir_out_valid", {31'b0, out_valid}, 32'h0);
      exp_pc     = {rpc[31:2], 2'b00};
      prev_stall = 1'b0;
      idle       = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'b0, out_valid}, 32'h1);
        check("hold_pc", out_pc, prev_pc);
        check("hold_instr", out_instr, prev_instr);
      end
      if (out_valid && rdy) begin
        check("acc_pc", out_pc, exp_pc);
        check("acc_instr", out_instr, exp_pc ^ Key);
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      if (rdy && !out_valid) begin
        idle++;
        check("gap_len", 32'(idle <= 1), 32'h1);
      end else begin
        idle = 0;
      end
      prev_stall = out_valid && !rdy;
      prev_pc    = out_pc;
      prev_instr = out_instr;
    end
  endtask

  // Stream with out_ready=1 until the scoreboard reaches target.
  task automatic wait_acc(input logic [31:0] target, input int budget, input string tag);
    for (int i = 0; i < budget && exp_pc != target; i++) cycle(1'b0, 32'h0, 1'b1);
    check(tag, exp_pc, target);
  endtask

  initial begin
    int acc0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    n_acc          = 0;
    sb_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_imem_addr", imem_addr, ResetPc);
    @(negedge clk);
    rst = 1'b0;

    // Stream: first word one cycle after reset release, one per cycle.
    acc0 = n_acc;
    cycle(1'b0, 32'h0, 1'b1);
    check("first_valid", {31'b0, obs_valid}, 32'h1);
    check("first_pc", obs_pc, ResetPc);
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    check("stream_count", n_acc - acc0, 32'd4);

    // Back-pressure on pc 0x10 for three cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      check("bp_valid", {31'b0, obs_valid}, 32'h1);
      check("bp_pc", obs_pc, 32'h10);
    end
    wait_acc(32'h1C, 6, "bp_resume");

    // Redirect while the skid holds 0x20.
    wait_acc(32'h20, 4, "reach_20");
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    check("skid_full", {31'b0, dut.skid_valid_q}, 32'h1);
    check("skid_pc", obs_pc, 32'h20);
    cycle(1'b1, 32'h103, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_bubble", {31'b0, obs_valid}, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    check("redir_t2_valid", {31'b0, obs_valid}, 32'h1);
    check("redir_t2_pc", obs_pc, 32'h100);

    // Redirect with out_ready=1 in the same cycle.
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h200, 1'b1);
    wait_acc(32'h208, 4, "redir_ready_resume");

    // Address wrap.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    wait_acc(32'h4, 5, "wrap");

    // Asynchronous reset in the middle of a stall with skid full.
    repeat (2) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    check("pre_rst_skid", {31'b0, dut.skid_valid_q}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_addr", imem_addr, ResetPc);
    @(negedge clk);
    #1;
    check("rst_hold_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sb_reset();
    cycle(1'b0, 32'h0, 1'b1);
    check("restart_valid", {31'b0, obs_valid}, 32'h1);
    check("restart_pc", obs_pc, ResetPc);

    // Random back-pressure and redirects.
    acc0 = n_acc;
    for (int i = 0; i < 600; i++) begin
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      cycle(rv, rpc, rdy);
    end
    check("random_progress", 32'(n_acc - acc0 > 100), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
